gcm_block_scheduler: RTL and testbench

//  Sequences one GCM instance (AAD + text) into per-block work items and dispatches them

---
 rtl/gcm_pkg.sv | 47 ++++
 rtl/gcm_rr_pointer.sv | 20 ++
 rtl/gcm_block_scheduler.sv | 145 ++++++++++++++
 tb/tb_gcm_block_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcm_pkg.sv
// Shared types and constants for the GCM block scheduler.
// The optional stall counter is enabled with GCM_SCHED_STALL_CNT_EN (see gcm_block_scheduler).
package gcm_pkg;

  localparam int          BLOCK_BITS   = 128;
  localparam logic [31:0] CTR_J0_FIRST = 32'd2;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'b100,
    PH_AAD   = 3'b010,
    PH_FIRST = 3'b000,
    PH_TEXT  = 3'b001,
    PH_LAST  = 3'b011,
    PH_SOLE  = 3'b111
  } phase_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [31:0] ctr32;
    phase_t      phase;
  } blk_info_t;

  // Counter word and phase tag for block idx; AAD blocks come first and carry ctr32 = 0.
  function automatic blk_info_t block_info(input logic [31:0] idx,
                                           input logic [31:0] aad_blk,
                                           input logic [31:0] txt_blk);
    blk_info_t   r;
    logic [31:0] k;
    k       = idx - aad_blk;
    r.ctr32 = '0;
    r.phase = PH_AAD;
    if (idx >= aad_blk) begin
      r.ctr32 = CTR_J0_FIRST + k;
      if (txt_blk == 32'd1)                r.phase = PH_SOLE;
      else if (k == 32'd0)                 r.phase = PH_FIRST;
      else if (k == txt_blk - 32'd1)       r.phase = PH_LAST;
      else                                 r.phase = PH_TEXT;
    end
    return r;
  endfunction

endpackage

// File: rtl/gcm_rr_pointer.sv
// Modulo-N round-robin pointer; restarts at 0 on clear, steps once per accepted handshake.
// No configuration macros apply to this file.
module gcm_rr_pointer #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  output logic [PTR_W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (!rst_n)       ptr <= '0;
    else if (clear)   ptr <= '0;
    else if (advance) ptr <= (ptr == PTR_W'(N - 1)) ? '0 : ptr + PTR_W'(1);
  end

endmodule

// File: rtl/gcm_block_scheduler.sv
// Splits one GCM instance into 128-bit work items and deals them round-robin to AES workers.
// Define GCM_SCHED_STALL_CNT_EN to add o_stall_cnt (ISSUE cycles spent waiting on a worker).
module gcm_block_scheduler
  import gcm_pkg::*;
#(
  parameter int NUM_WORKERS = 2,
  parameter int MAX_BLOCKS  = 100000,
  parameter int IDX_W       = 17
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic [63:0]            i_aad_bits,
  input  logic [63:0]            i_text_bits,
  input  logic [95:0]            i_iv,
  input  logic [NUM_WORKERS-1:0] i_wrk_ready,
  output logic [NUM_WORKERS-1:0] o_wrk_valid,
  output logic [127:0]           o_counter,
  output logic [IDX_W-1:0]       o_block_idx,
  output logic [2:0]             o_phase,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output sched_state_t           dbg_state
`ifdef GCM_SCHED_STALL_CNT_EN
  ,
  output logic [31:0]            o_stall_cnt
`endif
);

  localparam int PTR_W = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;

  sched_state_t     state, state_nxt;
  logic [95:0]      iv_q;
  logic [IDX_W-1:0] aad_blk_q, txt_blk_q, last_idx_q, idx_q;
  logic [31:0]      ctr_q;
  phase_t           phase_q;
  logic             err_q;
  logic [PTR_W-1:0] rr;
  logic [57:0]      aad_blk_in, txt_blk_in;
  logic [58:0]      total_in;
  logic             start_seen, too_big, start_acc, start_err, valid, hs, last;
  blk_info_t        first_info, next_info;

  assign aad_blk_in = 58'(({1'b0, i_aad_bits} + 65'd127) >> 7);
  assign txt_blk_in = 58'(({1'b0, i_text_bits} + 65'd127) >> 7);
  assign total_in   = {1'b0, aad_blk_in} + {1'b0, txt_blk_in};

  assign start_seen = (state == IDLE) && i_start;
  assign too_big    = total_in > 59'(MAX_BLOCKS);
  assign start_acc  = start_seen && !too_big;
  assign start_err  = start_seen && too_big;

  // Handshake: a block transfers on a cycle where valid is high for worker rr and
  // i_wrk_ready[rr] is high; until then every presented field holds steady.
  assign valid = (state == ISSUE);
  assign hs    = valid && i_wrk_ready[rr];
  assign last  = (idx_q == last_idx_q);

  assign first_info = block_info('0, 32'(aad_blk_in), 32'(txt_blk_in));
  assign next_info  = block_info(32'(idx_q) + 32'd1, 32'(aad_blk_q), 32'(txt_blk_q));

  gcm_rr_pointer #(.N(NUM_WORKERS), .PTR_W(PTR_W)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start_acc),
    .advance (hs),
    .ptr     (rr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_acc) state_nxt = (total_in == '0) ? DONE : ISSUE;
      ISSUE:   if (hs && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iv_q       <= '0;
      aad_blk_q  <= '0;
      txt_blk_q  <= '0;
      last_idx_q <= '0;
      idx_q      <= '0;
      ctr_q      <= '0;
      phase_q    <= PH_IDLE;
      err_q      <= 1'b0;
    end else begin
      err_q <= start_err;
      if (start_acc) begin
        iv_q       <= i_iv;
        aad_blk_q  <= IDX_W'(aad_blk_in);
        txt_blk_q  <= IDX_W'(txt_blk_in);
        last_idx_q <= IDX_W'(total_in - 59'd1);
        idx_q      <= '0;
        if (total_in != '0) begin
          ctr_q   <= first_info.ctr32;
          phase_q <= first_info.phase;
        end
      end else if (hs) begin
        if (last) begin
          idx_q   <= '0;
          ctr_q   <= '0;
          phase_q <= PH_IDLE;
        end else begin
          idx_q   <= idx_q + IDX_W'(1);
          ctr_q   <= next_info.ctr32;
          phase_q <= next_info.phase;
        end
      end
    end
  end

  always_comb begin
    o_wrk_valid = '0;
    if (valid) o_wrk_valid[rr] = 1'b1;
  end

  assign o_counter   = {iv_q, ctr_q};
  assign o_block_idx = idx_q;
  assign o_phase     = phase_q;
  assign o_busy      = valid;
  assign o_done      = (state == DONE);
  assign o_err       = err_q;
  assign dbg_state   = state;

`ifdef GCM_SCHED_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk) begin
    if (!rst_n)                                     stall_q <= '0;
    else if (start_acc)                             stall_q <= '0;
    else if (valid && !i_wrk_ready[rr] && stall_q != '1) stall_q <= stall_q + 32'd1;
  end
  assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_gcm_block_scheduler.sv
// Self-checking bench for gcm_block_scheduler; checks o_stall_cnt when GCM_SCHED_STALL_CNT_EN is defined.
module tb_gcm_block_scheduler;
  import gcm_pkg::*;

  localparam int NUM_WORKERS = 2;
  localparam int MAX_BLOCKS  = 100000;
  localparam int IDX_W       = 17;
  localparam int EXP_W       = 4 + 3 + IDX_W + 128;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   i_start;
  logic [63:0]            i_aad_bits, i_text_bits;
  logic [95:0]            i_iv;
  logic [NUM_WORKERS-1:0] i_wrk_ready;
  logic [NUM_WORKERS-1:0] o_wrk_valid;
  logic [127:0]           o_counter;
  logic [IDX_W-1:0]       o_block_idx;
  logic [2:0]             o_phase;
  logic                   o_busy, o_done, o_err;
  sched_state_t           dbg_state;
`ifdef GCM_SCHED_STALL_CNT_EN
  logic [31:0]            o_stall_cnt;
`endif

  gcm_block_scheduler #(.NUM_WORKERS(NUM_WORKERS), .MAX_BLOCKS(MAX_BLOCKS), .IDX_W(IDX_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_aad_bits  (i_aad_bits),
    .i_text_bits (i_text_bits),
    .i_iv        (i_iv),
    .i_wrk_ready (i_wrk_ready),
    .o_wrk_valid (o_wrk_valid),
    .o_counter   (o_counter),
    .o_block_idx (o_block_idx),
    .o_phase     (o_phase),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .dbg_state   (dbg_state)
`ifdef GCM_SCHED_STALL_CNT_EN
    ,
    .o_stall_cnt (o_stall_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int stall_obs = 0;
  int ready_mode = 0;   // 0 all ready, 1 random, 2 hold worker 1 off at idx 1
  int stall_left = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [EXP_W-1:0] obs, input logic [EXP_W-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic int blocks(input logic [63:0] bits);
    logic [64:0] s;
    s = ({1'b0, bits} + 65'd127) >> 7;
    return int'(s);
  endfunction

  // Reference model: one queue entry per block in dispatch order.
  task automatic push_expected(input logic [63:0] aad, input logic [63:0] text, input logic [95:0] iv);
    int          na, nt;
    logic [31:0] ctr;
    logic [2:0]  ph;
    na = blocks(aad);
    nt = blocks(text);
    for (int n = 0; n < na + nt; n++) begin
      if (n < na) begin
        ctr = 32'd0;
        ph  = 3'b010;
      end else begin
        ctr = 32'(n - na + 2);
        if (nt == 1)               ph = 3'b111;
        else if (n - na == 0)      ph = 3'b000;
        else if (n - na == nt - 1) ph = 3'b011;
        else                       ph = 3'b001;
      end
      exp_q.push_back({4'(n % NUM_WORKERS), ph, IDX_W'(n), iv, ctr});
    end
  endtask

  // ---------------- ready driver ----------------
  initial begin
    i_wrk_ready = '1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: for (int i = 0; i < NUM_WORKERS; i++) i_wrk_ready[i] = ($urandom_range(0, 3) != 0);
        2: begin
          i_wrk_ready = '1;
          if (o_wrk_valid[1] && o_block_idx == IDX_W'(1) && stall_left > 0) begin
            i_wrk_ready[1] = 1'b0;
            stall_left--;
          end
        end
        default: i_wrk_ready = '1;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EXP_W-1:0] obs, snap, exp;
    bit prev_stall;
    int w;
    prev_stall = 0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
        continue;
      end
      check("valid_onehot0", EXP_W'($onehot0(o_wrk_valid)), EXP_W'(1));
      w = 0;
      for (int i = 0; i < NUM_WORKERS; i++) if (o_wrk_valid[i]) w = i;
      obs = {4'(w), o_phase, o_block_idx, o_counter};
      if (|o_wrk_valid) begin
        if (prev_stall) check("stall_hold", obs, snap);
        if (|(o_wrk_valid & i_wrk_ready)) begin
          check("exp_q_nonempty", EXP_W'(exp_q.size() != 0), EXP_W'(1));
          if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            check("blk", obs, exp);
          end
          prev_stall = 0;
        end else begin
          stall_obs++;
          prev_stall = 1;
          snap = obs;
        end
      end else begin
        prev_stall = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_start(input logic [63:0] aad, input logic [63:0] text, input logic [95:0] iv);
    @(posedge clk);
    #1;
    i_start = 1'b1;
    i_aad_bits = aad;
    i_text_bits = text;
    i_iv = iv;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic run_instance(input logic [63:0] aad, input logic [63:0] text,
                              input logic [95:0] iv, input bit timed);
    int total, waited;
    bit seen;
    total = blocks(aad) + blocks(text);
    push_expected(aad, text, iv);
    drive_start(aad, text, iv);
    waited = 0;
    seen = 0;
    while (!seen && waited < 5000) begin
      @(negedge clk);
      waited++;
      if (waited == 1 && total > 0) check("busy_after_start", EXP_W'(o_busy), EXP_W'(1));
      if (o_done) seen = 1;
    end
    check("done_seen", EXP_W'(seen), EXP_W'(1));
    if (timed) check("done_latency", EXP_W'(waited), EXP_W'(total + 1));
    check("queue_drained", EXP_W'(exp_q.size()), EXP_W'(0));
    check("busy_at_done", EXP_W'(o_busy), EXP_W'(0));
    @(negedge clk);
    check("done_one_cycle", EXP_W'(o_done), EXP_W'(0));
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit found;
    rst_n = 1'b0;
    i_start = 1'b0;
    i_aad_bits = '0;
    i_text_bits = '0;
    i_iv = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", EXP_W'(o_wrk_valid), EXP_W'(0));
    check("rst_phase", EXP_W'(o_phase), EXP_W'(3'b100));
    check("rst_flags", EXP_W'({o_busy, o_done, o_err}), EXP_W'(0));
    check("rst_counter_idx", EXP_W'({o_counter, o_block_idx}), EXP_W'(0));
    check("rst_state", EXP_W'(dbg_state), EXP_W'(IDLE));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // AAD + text, always ready
    run_instance(64'd256, 64'd384, 96'h0123_4567_89ab_cdef_0011_2233, 1'b1);
    // single partial text block
    run_instance(64'd0, 64'd100, 96'hdead_beef_cafe_f00d_1234_5678, 1'b1);

    // worker 1 held off for 4 cycles while idx 1 is presented
    stall_obs = 0;
    stall_left = 4;
    ready_mode = 2;
    run_instance(64'd256, 64'd384, 96'h5555_aaaa_5555_aaaa_5555_aaaa, 1'b0);
    check("stall_cycles", EXP_W'(stall_obs), EXP_W'(4));
`ifdef GCM_SCHED_STALL_CNT_EN
    check("stall_cnt", EXP_W'(o_stall_cnt), EXP_W'(4));
`endif
    ready_mode = 0;

    // empty instance and AAD-only instance
    run_instance(64'd0, 64'd0, 96'h1, 1'b1);
    run_instance(64'd128, 64'd0, 96'h2, 1'b1);

    // oversize instance is rejected, then a legal one proceeds
    drive_start(64'(MAX_BLOCKS + 1) * 64'd128, 64'd0, 96'h3);
    @(negedge clk);
    check("err_pulse", EXP_W'(o_err), EXP_W'(1));
    check("err_busy", EXP_W'({o_busy, o_wrk_valid}), EXP_W'(0));
    @(negedge clk);
    check("err_one_cycle", EXP_W'({o_err, o_busy}), EXP_W'(0));
    run_instance(64'd129, 64'd1, 96'h4, 1'b1);

    // reset at idx 2 of 5 aborts the instance
    push_expected(64'd256, 64'd384, 96'h6);
    drive_start(64'd256, 64'd384, 96'h6);
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (|o_wrk_valid && o_block_idx == IDX_W'(2)) found = 1;
    end
    check("reached_idx2", EXP_W'(found), EXP_W'(1));
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_valid", EXP_W'(o_wrk_valid), EXP_W'(0));
    check("abort_phase", EXP_W'(o_phase), EXP_W'(3'b100));
    check("abort_busy", EXP_W'(o_busy), EXP_W'(0));
    exp_q.delete();
    rst_n = 1'b1;
    run_instance(64'd0, 64'd300, 96'h7, 1'b1);

    // randomized sizes with random worker readiness
    ready_mode = 1;
    for (int t = 0; t < 4; t++)
      run_instance(64'($urandom_range(0, 700)), 64'($urandom_range(0, 1200)),
                   {$urandom, $urandom, $urandom}, 1'b0);
    ready_mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
